// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Load/store unit between the memory pipeline stage and a word-wide data
//   memory. The memory has a combinational read and a write on the clock edge.
//   The unit performs byte, halfword and word accesses at any byte alignment.
//   An access that crosses a word boundary is split into two word accesses.
//   A sub-word store is done as a read-merge-write of each touched word.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   req_valid     request present
//   req_ready     high only when idle; a request is accepted when valid & ready
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10/11 word
//   req_unsigned  loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address, any alignment
//   req_wdata     store data, right-justified
//   rsp_valid     one-cycle completion pulse for loads and stores
//   rsp_rdata     extended load data (0 for stores)
//   mem_we        memory write enable
//   mem_a         memory word index (byte address >> 2)
//   mem_wd        merged write word
//   mem_rd        combinational read data for mem_a
module lsu_mem_master #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t                state;
    logic [AW-1:0]         addr_q;
    logic [1:0]            size_q;
    logic                  we_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] asm_q;

    logic [2:0]            nbytes;
    logic [2:0]            span;
    logic                  crossing;
    logic                  in_acc;
    logic [AW-3:0]         word_idx;
    logic [AW-3:0]         word_nxt;
    logic [2:0]            sidx;
    logic [DATA_WIDTH-1:0] asm_nxt;
    logic [DATA_WIDTH-1:0] wd_merge;

    // Sign or zero extension of the assembled load value.
    function automatic logic [DATA_WIDTH-1:0] extend(
        input logic [DATA_WIDTH-1:0] v,
        input logic [1:0]            sz,
        input logic                  uns
    );
        logic signed [7:0]            b;
        logic signed [15:0]           h;
        logic signed [DATA_WIDTH-1:0] r;
        b = v[7:0];
        h = v[15:0];
        case (sz)
            2'b00:   begin r = b; extend = uns ? {24'd0, v[7:0]}  : r; end
            2'b01:   begin r = h; extend = uns ? {16'd0, v[15:0]} : r; end
            default: extend = v;
        endcase
    endfunction

    always_comb begin
        case (size_q)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign span     = {1'b0, addr_q[1:0]} + nbytes;
    assign crossing = (span > 3'd4);
    assign in_acc   = (state == ACC0) || (state == ACC1);
    assign word_idx = addr_q[AW-1:2];
    assign word_nxt = word_idx + {{(AW-3){1'b0}}, 1'b1};

    // Lane mapping: sidx is the byte position within the access that memory
    // lane i carries. In ACC0 lanes below the offset wrap to large values and
    // fall outside nbytes; in ACC1 lane 0 continues after the first word.
    always_comb begin
        sidx     = '0;
        asm_nxt  = asm_q;
        wd_merge = mem_rd;
        for (int i = 0; i < 4; i++) begin
            if (state == ACC1)
                sidx = 3'(i) + (3'd4 - {1'b0, addr_q[1:0]});
            else
                sidx = 3'(i) - {1'b0, addr_q[1:0]};
            if (in_acc && (sidx < nbytes)) begin
                wd_merge[i*8 +: 8]                 = wdata_q[{sidx[1:0], 3'b000} +: 8];
                asm_nxt[{sidx[1:0], 3'b000} +: 8] = mem_rd[i*8 +: 8];
            end
        end
    end

    // Memory port is combinational from state and latched request; a write
    // is suppressed while reset is asserted.
    assign mem_we = we_q && in_acc && !rst;
    assign mem_wd = (we_q && in_acc) ? wd_merge : '0;

    always_comb begin
        case (state)
            ACC0:    mem_a = {2'b00, word_idx};
            ACC1:    mem_a = {2'b00, word_nxt};
            default: mem_a = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            asm_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        wdata_q   <= req_wdata;
                        asm_q     <= '0;
                        req_ready <= 1'b0;
                        state     <= ACC0;
                    end
                end
                ACC0: begin
                    asm_q <= asm_nxt;
                    if (crossing) begin
                        state <= ACC1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= we_q ? '0 : extend(asm_nxt, size_q, uns_q);
                    end
                end
                ACC1: begin
                    asm_q     <= asm_nxt;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= we_q ? '0 : extend(asm_nxt, size_q, uns_q);
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit on the pipeline side of the data memory port. It accepts one load or store request at a time from the memory stage and drives the word-wide data memory.
- The memory has a combinational read and a write on the clock edge.
- The block implements byte and halfword accesses, sign and zero extension, and stores narrower than a word by read-merge-write.
- An access that crosses a word boundary is split into two word accesses.

Parameters:
- ADDRESS_WIDTH, 32, width of byte addresses and of the memory address bus.
- DATA_WIDTH, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high in IDLE only; a request is accepted when req_valid and req_ready are both high.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is reserved and treated as word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDRESS_WIDTH  byte address; misalignment is allowed.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse, for loads and stores.
- rsp_rdata  out  DATA_WIDTH  extended load data; valid while rsp_valid is high. Stores return 0.
- mem_we  out  1  memory write enable.
- mem_a  out  ADDRESS_WIDTH  memory word index, equal to byte address >> 2 with the top 2 bits zero.
- mem_wd  out  DATA_WIDTH  memory write data, a full merged word.
- mem_rd  in  DATA_WIDTH  memory combinational read data for mem_a.

Behaviour:
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, mem_we = 0, mem_a = 0, mem_wd = 0. Latched request registers clear to 0.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE → ACC0 on acceptance. On acceptance the block latches addr, size, we, unsigned and wdata. With req_valid low it stays in IDLE.
- ACC0:
  - Drives mem_a = addr[AW-1:2]. Let off = addr[1:0] and nbytes = 1, 2 or 4.
  - Loads capture bytes off .. min(3, off+nbytes-1) of mem_rd into assembly bytes 0.. in little-endian order.
  - Stores set mem_we = 1. mem_wd is mem_rd with those lanes replaced by the low bytes of wdata. Other lanes keep mem_rd.
  - If off + nbytes > 4, go to ACC1; otherwise go to RESP.
- ACC1:
  - Drives mem_a = addr[AW-1:2] + 1, which wraps modulo 2^(AW-2).
  - Handles the remaining off + nbytes - 4 bytes in lanes 0.. of that word, using the same capture and merge rules as ACC0.
  - Goes to RESP.
- RESP:
  - rsp_valid = 1. For loads, rsp_rdata = assembled value extended from 8, 16 or 32 bits according to req_unsigned. For stores, rsp_rdata = 0.
  - Goes to IDLE. req_ready returns high in the following cycle.
- mem_we is 0 in IDLE and RESP and for loads in every state. At most one write per ACC state, so a store performs 1 or 2 writes.
- mem_a, mem_wd and mem_we are combinational from the state and latched registers. mem_a/mem_wd = 0 in IDLE and RESP.
- Latency: acceptance at edge N.
  - Aligned (non-crossing) access: rsp_valid is high in the cycle after edge N+1.
  - Crossing access: rsp_valid is one cycle later.
  - Throughput is one request per 3 or 4 cycles.
- Requests presented while req_ready = 0 are ignored and not queued. Any change to req_* while busy has no effect.
- Reset mid-operation: at the next edge the block returns to IDLE with reset values. A write already committed at an earlier edge is not undone. If rst is high during an ACC state, that state's write is suppressed and mem_we is forced to 0 while rst is high.

Test Plan:
- Preload word index 0x1000 = 0x44332211 and 0x1001 = 0x88776655.
- Load-byte extension: lb at 0x4007 → rsp_rdata = 0xFFFFFF88. lbu at 0x4007 → 0x00000088. lh at 0x4004 → 0x00006655. Each rsp_valid fires 2 cycles after acceptance, and mem_we stays 0 throughout.
- Sub-word store: sh 0x0000BEEF at 0x4001 → a single mem_we pulse with mem_a = 0x1000 and mem_wd = 0x44BEEF11. A following lw at 0x4000 returns 0x44BEEF11.
- Misaligned load: lw at 0x4002 → mem_a sequence is 0x1000 then 0x1001. rsp_rdata = 0x66554433, and rsp_valid fires 3 cycles after acceptance.
- Misaligned store: sw 0xDEADBEEF at 0x4003 → two writes, word 0x1000 = 0xEF332211 and word 0x1001 = 0x88DEADBE.
- Busy handling: hold req_valid with a second request during an operation → only the first executes. req_ready stays low until IDLE, then the second is accepted. Also check address wrap: lw at 0xFFFFFFFE → second access at mem_a = 0x00000000.
- Reset mid-op: assert rst during ACC1 of the sw at 0x4003 → word 0x1000 is updated, word 0x1001 is unchanged, no rsp_valid is produced, and req_ready = 1 after the reset edge.
